// File: rtl/easyobv_axil_regs_if.sv
// easyobv_axil_regs_if
// Purpose: groups the five AXI4-Lite channels used by easyobv_axil_regs.
// Parameters: ADDR_WIDTH - byte address width of awaddr/araddr.
// Modports:
//   master - drives addresses, write data/strobes, valids and bready/rready.
//   slave  - drives awready/wready, bresp/bvalid, arready and rdata/rresp/rvalid.
interface easyobv_axil_regs_if #(
  parameter int ADDR_WIDTH = 8
);
  logic [ADDR_WIDTH-1:0] awaddr;
  logic                  awvalid;
  logic                  awready;
  logic [31:0]           wdata;
  logic [3:0]            wstrb;
  logic                  wvalid;
  logic                  wready;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic                  arvalid;
  logic                  arready;
  logic [31:0]           rdata;
  logic [1:0]            rresp;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/easyobv_axil_regs.sv
// easyobv_axil_regs
// Purpose: AXI4-Lite register slave in the s_axil_aclk domain. Consumes the
// synchronised statistics counters and timeout/mismatch flags, offers coherent
// 64-bit snapshots, sticky status bits, a pause level and a stretched clear
// pulse long enough for a 5-stage level synchroniser in the traffic domain.
// Ports:
//   s_axil_aclk, s_axil_aresetn - register clock, async active-low reset.
//   s_axil                      - AXI4-Lite slave bundle (easyobv_axil_regs_if).
//   *_axil 64-bit inputs        - seven synchronised counters.
//   timeout_axil, mismatch_axil - synchronised level flags.
//   pause_axil, clear_axil      - controls back toward the traffic domain.
// Build option: define EASYOBV_AXIL_AUTO_SNAPSHOT_EN so that reading a counter's
// lo word returns the live lo half and latches the live hi half into the hi
// shadow; undefined, both words come from SNAPSHOT captures only.
module easyobv_axil_regs #(
  parameter int          ADDR_WIDTH = 8,
  parameter int          CLEAR_HOLD = 16,
  parameter logic [31:0] VERSION    = 32'h0001_0000
) (
  input  logic               s_axil_aclk,
  input  logic               s_axil_aresetn,
  easyobv_axil_regs_if.slave s_axil,
  input  logic [63:0]        tx_pkt_cnt_axil,
  input  logic [63:0]        tx_time_elapsed_axil,
  input  logic [63:0]        tx_transferred_size_axil,
  input  logic [63:0]        rx_pkt_cnt_axil,
  input  logic [63:0]        rx_time_elapsed_axil,
  input  logic [63:0]        rx_transferred_size_axil,
  input  logic [63:0]        latency_sum_axil,
  input  logic               timeout_axil,
  input  logic               mismatch_axil,
  output logic               pause_axil,
  output logic               clear_axil
);
  localparam int CW   = $clog2(CLEAR_HOLD + 1);
  localparam int NCNT = 7;

  logic [ADDR_WIDTH-1:0] awAddr, arAddr;
  logic [5:0]            wIdx, rIdx;
  logic [63:0]           live [NCNT];

  logic        awready_q, bvalid_q, arready_q, rvalid_q;
  logic [1:0]  bresp_q, rresp_q;
  logic [31:0] rdata_q;
  logic        pause_q, clear_q;
  logic [CW-1:0] clrCnt_q, clrCnt_d;
  logic [1:0]  flagPrev_q, sticky_q, sticky_d, stickyW1c, flagRise;
  logic [31:0] snapCnt_q;
  logic [63:0] shadow_q [NCNT];

  logic        wrFire, rdFire, wrHit, ctrlWr, clrReq, snapReq;
  logic [31:0] rdData;
  logic [1:0]  rdResp;
  logic        unusedBits;

  assign awAddr = s_axil.awaddr;
  assign arAddr = s_axil.araddr;
  assign wIdx   = awAddr[7:2];
  assign rIdx   = arAddr[7:2];

  assign live[0] = tx_pkt_cnt_axil;
  assign live[1] = tx_time_elapsed_axil;
  assign live[2] = tx_transferred_size_axil;
  assign live[3] = rx_pkt_cnt_axil;
  assign live[4] = rx_time_elapsed_axil;
  assign live[5] = rx_transferred_size_axil;
  assign live[6] = latency_sum_axil;

  assign s_axil.awready = awready_q;
  assign s_axil.wready  = awready_q;
  assign s_axil.bvalid  = bvalid_q;
  assign s_axil.bresp   = bresp_q;
  assign s_axil.arready = arready_q;
  assign s_axil.rvalid  = rvalid_q;
  assign s_axil.rdata   = rdata_q;
  assign s_axil.rresp   = rresp_q;
  assign pause_axil     = pause_q;
  assign clear_axil     = clear_q;

  assign unusedBits = ^{awAddr, arAddr, s_axil.wdata, s_axil.wstrb};

  function automatic logic isMapped(input logic [5:0] idx);
    return (idx <= 6'd2) || ((idx >= 6'd4) && (idx <= 6'd17)) || (idx == 6'd63);
  endfunction

  // A write is taken in the cycle awready/wready are high with both valids
  // present; all register side effects are decoded from that single cycle.
  assign wrFire  = awready_q && s_axil.awvalid && s_axil.wvalid;
  assign rdFire  = arready_q && s_axil.arvalid;
  assign wrHit   = wrFire && s_axil.wstrb[0] && isMapped(wIdx);
  assign ctrlWr  = wrHit && (wIdx == 6'd0);
  assign clrReq  = ctrlWr && s_axil.wdata[1];
  assign snapReq = wrHit && (wIdx == 6'd2);

  // Sticky bits: clears (W1C or a CTRL clear) are applied first and a fresh
  // rising edge is OR'd in afterwards, so a coincident set always survives.
  assign stickyW1c = (wrHit && (wIdx == 6'd1)) ? s_axil.wdata[3:2] : 2'b00;
  assign flagRise  = {mismatch_axil & ~flagPrev_q[1], timeout_axil & ~flagPrev_q[0]};
  assign sticky_d  = (sticky_q & ~stickyW1c & ~{2{clrReq}}) | flagRise;

  // Clear hold counter: a request (re)loads it, otherwise it counts down to 0.
  assign clrCnt_d = clrReq ? CW'(CLEAR_HOLD) :
                    (clrCnt_q != '0) ? clrCnt_q - CW'(1) : clrCnt_q;

  // Read mux works from the current register state, so a read accepted in the
  // same cycle as a CTRL or SNAPSHOT write sees the pre-write value.
  always_comb begin
    rdData = '0;
    rdResp = 2'b00;
    if (rIdx == 6'd0) begin
      rdData = {30'd0, clear_q, pause_q};
    end else if (rIdx == 6'd1) begin
      rdData = {28'd0, sticky_q, mismatch_axil, timeout_axil};
    end else if (rIdx == 6'd2) begin
      rdData = snapCnt_q;
    end else if (rIdx == 6'd63) begin
      rdData = VERSION;
    end else if ((rIdx >= 6'd4) && (rIdx <= 6'd17)) begin
      for (int i = 0; i < NCNT; i++) begin
`ifdef EASYOBV_AXIL_AUTO_SNAPSHOT_EN
        if (rIdx == 6'(4 + 2 * i)) rdData = live[i][31:0];
`else
        if (rIdx == 6'(4 + 2 * i)) rdData = shadow_q[i][31:0];
`endif
        if (rIdx == 6'(5 + 2 * i)) rdData = shadow_q[i][63:32];
      end
    end else begin
      rdResp = 2'b10;
    end
  end

  // Handshake engine: readies are registered one-cycle pulses, and each
  // channel holds at most one transaction until its response is taken.
  always_ff @(posedge s_axil_aclk or negedge s_axil_aresetn) begin
    if (!s_axil_aresetn) begin
      awready_q <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= 2'b00;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= 2'b00;
    end else begin
      awready_q <= s_axil.awvalid && s_axil.wvalid && !bvalid_q && !awready_q;
      if (wrFire) begin
        bvalid_q <= 1'b1;
        bresp_q  <= isMapped(wIdx) ? 2'b00 : 2'b10;
      end else if (bvalid_q && s_axil.bready) begin
        bvalid_q <= 1'b0;
      end
      arready_q <= s_axil.arvalid && !rvalid_q && !arready_q;
      if (rdFire) begin
        rvalid_q <= 1'b1;
        rdata_q  <= rdData;
        rresp_q  <= rdResp;
      end else if (rvalid_q && s_axil.rready) begin
        rvalid_q <= 1'b0;
      end
    end
  end

  // Control and status state: pause level, clear stretcher, flag edge
  // history, sticky bits and the snapshot counter.
  always_ff @(posedge s_axil_aclk or negedge s_axil_aresetn) begin
    if (!s_axil_aresetn) begin
      pause_q    <= 1'b0;
      clear_q    <= 1'b0;
      clrCnt_q   <= '0;
      flagPrev_q <= 2'b00;
      sticky_q   <= 2'b00;
      snapCnt_q  <= '0;
    end else begin
      if (ctrlWr) pause_q <= s_axil.wdata[0];
      clrCnt_q   <= clrCnt_d;
      clear_q    <= (clrCnt_d != '0);
      flagPrev_q <= {mismatch_axil, timeout_axil};
      sticky_q   <= sticky_d;
      if (snapReq) snapCnt_q <= snapCnt_q + 32'd1;
    end
  end

  // Shadow counters: a clear wins over a snapshot, which wins over the
  // per-counter hi latch taken on a lo-word read.
  always_ff @(posedge s_axil_aclk or negedge s_axil_aresetn) begin
    if (!s_axil_aresetn) begin
      for (int i = 0; i < NCNT; i++) shadow_q[i] <= '0;
    end else begin
      for (int i = 0; i < NCNT; i++) begin
`ifdef EASYOBV_AXIL_AUTO_SNAPSHOT_EN
        if (rdFire && (rIdx == 6'(4 + 2 * i))) shadow_q[i][63:32] <= live[i][63:32];
`endif
        if (snapReq) shadow_q[i] <= live[i];
        if (clrReq) shadow_q[i] <= '0;
      end
    end
  end
endmodule

// File: doc/easyobv_axil_regs.md
Name: easyobv_axil_regs

Overview:
- AXI4-Lite register slave in the s_axil_aclk domain.
- Directly downstream of the statistics clock-domain crossing: consumes the seven synchronised 64-bit counters and the synchronised timeout/mismatch flags.
- Drives the pause/clear controls that the crossing carries back to the traffic clock.
- Provides coherent 64-bit snapshots, sticky status bits and a stretched clear pulse long enough for a 5-stage level synchroniser.

Parameters:
- ADDR_WIDTH, 8, AXI-Lite byte address width; only bits [7:2] are decoded.
- CLEAR_HOLD, 16, s_axil_aclk cycles clear_axil stays high per clear request (min 8).
- VERSION, 32'h0001_0000, value returned at ID register 0xFC.

Ports:
- s_axil_aclk  in  1  register clock.
- s_axil_aresetn  in  1  asynchronous active-low reset.
- s_axil_awaddr/awvalid/awready  in/in/out  ADDR_WIDTH/1/1  write address channel.
- s_axil_wdata/wstrb/wvalid/wready  in/in/in/out  32/4/1/1  write data channel.
- s_axil_bresp/bvalid/bready  out/out/in  2/1/1  write response channel.
- s_axil_araddr/arvalid/arready  in/in/out  ADDR_WIDTH/1/1  read address channel.
- s_axil_rdata/rresp/rvalid/rready  out/out/out/in  32/2/1/1  read data channel.
- tx_pkt_cnt_axil, tx_time_elapsed_axil, tx_transferred_size_axil, rx_pkt_cnt_axil, rx_time_elapsed_axil, rx_transferred_size_axil, latency_sum_axil  in  64 each  synchronised counters.
- timeout_axil, mismatch_axil  in  1 each  synchronised level flags.
- pause_axil  out  1  pause request toward the traffic domain.
- clear_axil  out  1  stretched clear request toward the traffic domain.

Behaviour:
- Reset (async assert, sync release):
  - All ready/valid outputs, pause_axil, clear_axil, sticky bits, snapshot shadows and SNAP_CNT are 0.
  - bresp/rresp are 2'b00 and rdata is 0.
- Write handshake:
  - awready and wready pulse together for one cycle when awvalid && wvalid && !bvalid.
  - The register update happens in that cycle.
  - bvalid rises the next cycle and holds until bready.
  - No further write is accepted while bvalid is high.
- Read handshake:
  - arready pulses when arvalid && !rvalid.
  - rdata/rresp are registered, so rvalid rises one cycle after acceptance and holds (data stable) until rready.
  - Each channel keeps one transaction outstanding at most.
- Response codes: unmapped address returns SLVERR (2'b10) with rdata 0, and an unmapped write has no effect. Writes to read-only registers are ignored and return OKAY.
- Register map:
  - 0x00 CTRL (RW):
    - bit0 pause: level; drives pause_axil directly from a flop.
    - bit1 clear: writing 1 loads the hold counter with CLEAR_HOLD and drives clear_axil high until the counter reaches 0. Reads back 1 while active. A rewrite while active reloads the counter. Writing 0 has no effect.
    - Both bits are updated only if wstrb[0] is set.
  - 0x04 STATUS:
    - bit0 timeout (live), bit1 mismatch (live).
    - bit2 timeout sticky, bit3 mismatch sticky: each set on a rising edge of its live flag; write-1-to-clear with wstrb[0].
    - If set and clear coincide in the same cycle, set wins.
  - 0x08 SNAPSHOT:
    - Any write with wstrb[0] copies all seven live counters into shadow registers in the write cycle and increments SNAP_CNT.
    - A read returns SNAP_CNT (32-bit, wraps 0xFFFF_FFFF->0).
  - 0x10..0x44: shadow counters, lo word at the even address and hi word at +4, in this order:
    - 0x10 tx_pkt_cnt, 0x18 tx_time_elapsed, 0x20 tx_transferred_size.
    - 0x28 rx_pkt_cnt, 0x30 rx_time_elapsed, 0x38 rx_transferred_size.
    - 0x40 latency_sum.
  - 0xFC ID: returns VERSION.
- Clear side effect: a clear request also zeroes all shadows and both sticky bits in the write cycle. SNAP_CNT is unaffected.
- Same-cycle read and write: a read accepted in the same cycle as a SNAPSHOT or CTRL write returns the pre-write value.
- Reset asserted mid-transaction: all handshakes drop immediately, and the in-flight transaction is lost with no response issued.

Optional Feature:
- EASYOBV_AXIL_AUTO_SNAPSHOT_EN defined:
  - Reading a lo word returns the live lo 32 bits and, in the same acceptance cycle, latches the live hi 32 bits of that counter into its hi shadow.
  - Reading the hi word returns that shadow, giving per-counter coherence without a SNAPSHOT write.
  - The SNAPSHOT register still functions.
- Undefined: lo and hi words both return SNAPSHOT-captured shadows only.

Test Plan:
- Reset, then read 0xFC -> rdata 0x0001_0000, rresp 00; read 0x00 -> 0.
- Counters: set tx_pkt_cnt_axil=64'h0000_0001_FFFF_FFFF and write 0x08. Then change the input to 64'h2_0000_0000 and read 0x10/0x14 -> 0xFFFF_FFFF / 0x0000_0001. Read 0x08 -> 1.
- Clear pulse: write 0x00 = 0x2 -> clear_axil high exactly 16 cycles. Rewrite at cycle 10 -> high 26 cycles total. Shadows read 0 afterwards.
- Sticky status: pulse mismatch_axil 0->1->0, read 0x04 -> 0x8. Write 0x04 = 0x8 -> reads 0x0. Clear coinciding with a new rising edge -> bit3 stays 1.
- Handshake: awvalid two cycles before wvalid -> awready/wready pulse together once both are valid. Hold bready low 5 cycles -> bvalid held and no second write accepted. Read 0x80 -> rresp 2'b10, rdata 0.
- With EASYOBV_AXIL_AUTO_SNAPSHOT_EN: latency_sum_axil=64'h5_0000_0010, read 0x40 -> 0x10. Change the input to 64'h6_0000_0000, read 0x44 -> 0x5.
